// File: rtl/mlp_dot_mac.sv
// Weight-row consumer: fetches one BRAM weight row, computes a lane-serial
// unsigned dot product with the latched activations, and requantizes it.
module mlp_dot_mac #(
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTPUT_SIZE = 32,
    parameter int ADDR_WIDTH      = 3,
    parameter int LANES           = 4,
    parameter int ACC_WIDTH       = 24,
    parameter int FETCH_LAT       = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [ADDR_WIDTH-1:0]                        row_addr,
    input  logic [$clog2(MAX_OUTPUT_SIZE+1)-1:0]         vec_len,
    input  logic [4:0]                                   shift,
    input  logic [MAX_OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]   act_in,
    output logic                                         read_en,
    output logic [ADDR_WIDTH-1:0]                        rd_addr,
    input  logic [MAX_OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]   wt_in,
    input  logic                                         wt_ready,
    output logic                                         busy,
    output logic                                         done,
    output logic [ACC_WIDTH-1:0]                         acc_out,
    output logic [DATA_WIDTH-1:0]                        q_out,
    output logic                                         sat,
    output logic [1:0]                                   dbg_state
);
    localparam int LEN_W = $clog2(MAX_OUTPUT_SIZE + 1);
    localparam int IDX_W = $clog2(MAX_OUTPUT_SIZE);
    localparam int FC_W  = $clog2(FETCH_LAT + 1);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam logic [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'((2 ** DATA_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

    state_t                                     state, state_next;
    logic [ADDR_WIDTH-1:0]                      addr_r;
    logic [LEN_W-1:0]                           vlen_r, vlen_clamped, idx, elem;
    logic [4:0]                                 shift_r;
    logic [MAX_OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] act_r, wt_r;
    logic [ACC_WIDTH-1:0]                       acc, lane_sum, acc_next, shifted;
    logic [PW-1:0]                              prod;
    logic [FC_W-1:0]                            fcnt;
    logic                                       go_mac, last_mac, sat_next;

    // Handshake: start is taken only while busy=0; done marks acc_out/q_out/sat
    // valid for exactly one cycle, and they hold until the next done or reset.
    assign busy      = (state != IDLE);
    assign read_en   = (state == FETCH);
    assign rd_addr   = addr_r;
    assign dbg_state = state;

    assign vlen_clamped = (vec_len > LEN_W'(MAX_OUTPUT_SIZE)) ? LEN_W'(MAX_OUTPUT_SIZE) : vec_len;
    assign go_mac       = (fcnt >= FC_W'(FETCH_LAT)) && wt_ready;
    assign last_mac     = (idx + LEN_W'(LANES)) >= vlen_r;

    // Lanes past vec_len are masked so stale row data never reaches the sum.
    always_comb begin
        lane_sum = '0;
        elem     = '0;
        prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            elem = idx + LEN_W'(l);
            prod = PW'(act_r[elem[IDX_W-1:0]]) * PW'(wt_r[elem[IDX_W-1:0]]);
            if (elem < vlen_r)
                lane_sum = lane_sum + ACC_WIDTH'(prod);
        end
    end

    assign acc_next = acc + lane_sum;
    assign shifted  = acc_next >> shift_r;
    assign sat_next = shifted > Q_MAX;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = (vlen_clamped == '0) ? DONE : FETCH;
            FETCH: if (go_mac) state_next = MAC;
            MAC:   if (last_mac) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_r  <= '0;
            vlen_r  <= '0;
            shift_r <= '0;
            act_r   <= '0;
            wt_r    <= '0;
            acc     <= '0;
            idx     <= '0;
            fcnt    <= '0;
            done    <= 1'b0;
            acc_out <= '0;
            q_out   <= '0;
            sat     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr_r  <= row_addr;
                    vlen_r  <= vlen_clamped;
                    shift_r <= shift;
                    act_r   <= act_in;
                    acc     <= '0;
                    idx     <= '0;
                    fcnt    <= FC_W'(1);
                    if (vlen_clamped == '0) begin
                        acc_out <= '0;
                        q_out   <= '0;
                        sat     <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (go_mac)
                        wt_r <= wt_in;
                    else if (fcnt < FC_W'(FETCH_LAT))
                        fcnt <= fcnt + FC_W'(1);
                end
                MAC: begin
                    acc <= acc_next;
                    idx <= idx + LEN_W'(LANES);
                    if (last_mac) begin
                        acc_out <= acc_next;
                        q_out   <= sat_next ? '1 : shifted[DATA_WIDTH-1:0];
                        sat     <= sat_next;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mlp_dot_mac.md
# mlp_dot_mac

Weight-row consumer sitting directly downstream of the MLP weight BRAM. On `start` it latches an activation vector and a row address, fetches one weight row over the BRAM read port, and computes a lane-serial unsigned dot product. It then requantizes the result to `DATA_WIDTH` by right shift with saturation and reports it with a one-cycle `done` pulse. One instance computes one neuron output per invocation.

## Interface
- `DATA_WIDTH`, 8: element width of activations and weights (unsigned).
- `MAX_OUTPUT_SIZE`, 32: vector length of the BRAM row and activation bus.
- `ADDR_WIDTH`, 3: BRAM row address width.
- `LANES`, 4: multiply-accumulates per MAC cycle; must divide `MAX_OUTPUT_SIZE`.
- `ACC_WIDTH`, 24: accumulator width; must be ≥ 2·`DATA_WIDTH` + clog2(`MAX_OUTPUT_SIZE`).
- `FETCH_LAT`, 2: cycles `read_en` is held before the weight row is captured.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `start`  in  1  request; accepted only in IDLE.
- `row_addr`  in  `ADDR_WIDTH`  weight row to fetch; latched on accept.
- `vec_len`  in  clog2(`MAX_OUTPUT_SIZE`+1)  valid elements; latched on accept; values above `MAX_OUTPUT_SIZE` clamp to `MAX_OUTPUT_SIZE`.
- `shift`  in  5  requantization right shift; latched on accept.
- `act_in`  in  `DATA_WIDTH` × [`MAX_OUTPUT_SIZE`]  activation vector; latched on accept.
- `read_en`  out  1  BRAM read enable.
- `rd_addr`  out  `ADDR_WIDTH`  BRAM row address.
- `wt_in`  in  `DATA_WIDTH` × [`MAX_OUTPUT_SIZE`]  BRAM `data_out`.
- `wt_ready`  in  1  BRAM `data_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; outputs valid.
- `acc_out`  out  `ACC_WIDTH`  full-precision dot product.
- `q_out`  out  `DATA_WIDTH`  requantized result.
- `sat`  out  1  requantization saturated.

## Operation
- States are IDLE → FETCH → MAC → DONE → IDLE.
- IDLE: on `start`=1, latch inputs, clear the accumulator and element index, then go to FETCH. If the clamped `vec_len` is 0, go straight to DONE with acc = 0.
- FETCH:
  - Drive `read_en`=1 and `rd_addr`=latched `row_addr`, both stable for the whole state.
  - A wait counter counts FETCH cycles.
  - When the counter reaches `FETCH_LAT` and `wt_ready`=1, capture `wt_in` into the weight register and go to MAC.
  - If `wt_ready`=0 at that point, stay in FETCH, keep `read_en` high, and capture on the first later cycle with `wt_ready`=1.
- MAC:
  - Each cycle adds the products for elements idx..idx+`LANES`-1, then idx += `LANES`.
  - Elements with index ≥ `vec_len` contribute 0, whatever their data.
  - Leave after ceil(`vec_len`/`LANES`) cycles.
- DONE:
  - Register `acc_out`.
  - `q_out` = min(acc >> shift, 2^`DATA_WIDTH`−1).
  - `sat` = 1 iff clamping occurred.
  - Pulse `done` and return to IDLE.
- Arithmetic: products are 2·`DATA_WIDTH` bits, zero-extended to `ACC_WIDTH`. With the width rule, overflow cannot occur.
- `start` while `busy`=1 is ignored and not queued.
- Reset (any time, including mid-FETCH or mid-MAC): state IDLE, `read_en`=0, `rd_addr`=0, `busy`=0, `done`=0, `acc_out`=0, `q_out`=0, `sat`=0, internal registers cleared. The in-flight operation is dropped.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..`FETCH_LAT`: `read_en`=1. Capture occurs at the edge ending cycle `FETCH_LAT`, given `wt_ready`=1.
- MAC occupies N = ceil(`vec_len`/`LANES`) cycles; `read_en`=0 from the first MAC cycle.
- DONE and `done`=1 fall in cycle `FETCH_LAT`+1+N. Defaults with `vec_len`=32: N = 8, so `done` is in cycle 11.
- `vec_len`=0: `done` in cycle 1; `read_en` is never asserted.
- `acc_out`, `q_out` and `sat` are updated only in DONE and held until the next DONE or reset.
- A new `start` is accepted in the cycle after DONE at the earliest.

## Test plan
- Basic: row 0 = {2,0,5,3,…}, `act_in`={1,2,3,4,…}, `vec_len`=4, `shift`=0 → `done` at cycle 4; `acc_out`=29, `q_out`=29, `sat`=0; `rd_addr`=0 during FETCH.
- Masking: `vec_len`=5, all activations 1 and all weights 7 → `acc_out`=35; elements 5..31 ignored; `done` at cycle 5 (N = 2).
- Saturation: `vec_len`=32, all activations and weights 0xFF, `shift`=4 → `acc_out`=2080800, `q_out`=255, `sat`=1, `done` at cycle 11.
- Late ready: hold `wt_ready`=0 for 3 extra cycles → `read_en` stays high and `rd_addr` stays stable; `done` is delayed by 3 cycles and the result is unchanged.
- Busy/zero: `start` pulsed during MAC → ignored and `done` pulses once. `vec_len`=0 → `done` at cycle 1, `acc_out`=0, no `read_en`.
- Reset mid-MAC: drop `rst` low asynchronously in the second MAC cycle → all outputs are at reset values immediately; no `done` pulse. After release, a fresh `start` completes with the correct result.
